// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk cycles.
// Optional glitch filter compiled in with `define PWM_CAP_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int CW          = 9,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pwm_in,
   output logic [CW-1:0] high_cnt,
   output logic [CW-1:0] period_cnt,
   output logic          meas_valid,
   output logic          timeout,
   output logic          busy
);

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_sync, s, s_prev_q, rise, fall;
   state_e                 state_q;
   logic [CW-1:0]          cnt_q, hi_lat_q, high_cnt_q, period_cnt_q, cnt_inc;
   logic                   meas_valid_q, timeout_q, busy_q, sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end
   assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAP_GLITCH_FILTER_EN
   localparam int FCW = $clog2(FILT_LEN + 1);
   logic [FCW-1:0] fcnt_q;
   logic           filt_q;

   // Level flips only after FILT_LEN consecutive samples disagreeing with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q <= '0;
         filt_q <= 1'b0;
      end else if (s_sync == filt_q) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FCW'(FILT_LEN - 1)) begin
         fcnt_q <= '0;
         filt_q <= s_sync;
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end
   assign s = filt_q;
`else
   logic unused_filt_len;
   assign unused_filt_len = (FILT_LEN > 0);
   assign s = s_sync;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s_prev_q <= 1'b0;
      else        s_prev_q <= s;
   end

   assign rise    = s & ~s_prev_q;
   assign fall    = ~s & s_prev_q;
   assign sat     = (cnt_q == CNT_MAX);
   // Saturating increment: an edge on the saturation cycle must not wrap cnt.
   assign cnt_inc = sat ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hi_lat_q     <= '0;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  cnt_q   <= CW'(1);
                  state_q <= HIGH;
                  busy_q  <= 1'b1;
               end
            end
            HIGH: begin
               if (fall) begin
                  hi_lat_q <= cnt_q;
                  cnt_q    <= cnt_inc;
                  state_q  <= LOW;
               end else if (sat) begin
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            LOW: begin
               if (rise) begin
                  period_cnt_q <= cnt_q;
                  high_cnt_q   <= hi_lat_q;
                  meas_valid_q <= 1'b1;
                  cnt_q        <= CW'(1);
                  state_q      <= HIGH;
               end else if (sat) begin
                  timeout_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign high_cnt   = high_cnt_q;
   assign period_cnt = period_cnt_q;
   assign meas_valid = meas_valid_q;
   assign timeout    = timeout_q;
   assign busy       = busy_q;

endmodule
